icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Miss-refill sequencer for the instruction cache. Accepts one line-miss at a time from the icache lookup stage, issues a single line-aligned burst read to the memory side, writes each returned beat into the data array, then commits the tag/valid entry. It sits between the icache lookup pipeline, the tag/data arrays and the memory port.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, memory beat and array word width (multiple of 8)
- LINE_BYTES, 16, cache line size; BEATS = LINE_BYTES/(DATA_W/8), power of two, at least 2
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- miss_valid  in  1  lookup stage reports a miss; held with miss_addr until accepted
- miss_addr  in  ADDR_W  missing fetch address
- miss_ready  out  1  high only in IDLE
- mem_req_valid  out  1  burst read request
- mem_req_addr  out  ADDR_W  line-aligned address; stable while valid
- mem_req_ready  in  1  memory accepts the request
- mem_rsp_valid  in  1  beat valid; no backpressure
- mem_rsp_data  in  DATA_W  beat data
- mem_rsp_last  in  1  final beat
- mem_rsp_err  in  1  beat error
- arr_we  out  1  data-array write strobe
- arr_addr  out  ADDR_W  word-aligned byte address of the write
- arr_wdata  out  DATA_W  write data
- tag_we  out  1  tag/valid commit strobe; tag taken from arr_addr line bits
- refill_done  out  1  one-cycle pulse: line committed
- refill_err  out  1  one-cycle pulse: refill failed, tag not written
- fwd_valid / fwd_data  out  1 / DATA_W  critical-word forward; present only with ICACHE_REFILL_FWD_EN

## Operation
- FSM states: IDLE, REQ, FILL, DONE.
- IDLE: miss_ready=1. On miss_valid, latch the line address (offset bits cleared) and the word offset, clear the beat counter and error flag, and go to REQ.
- REQ: mem_req_valid=1. On mem_req_ready, go to FILL.
- FILL: on each mem_rsp_valid, register the beat. In the next cycle: arr_we=1, arr_addr = line + counter*(DATA_W/8), arr_wdata = beat. Counter increments modulo BEATS.
- Error flag is sticky and is set by any of:
  - mem_rsp_err on any beat
  - mem_rsp_last on a beat with index != BEATS-1
  - no mem_rsp_last on beat BEATS-1
- Burst terminates on mem_rsp_last or on beat BEATS-1, whichever comes first. Go to DONE.
- DONE (one cycle): last arr_we issues. If no error: tag_we=1 and refill_done=1. If error: tag_we=0 and refill_err=1. Next state is IDLE.
- mem_rsp_valid outside FILL is ignored. miss_valid outside IDLE is not accepted.

## Timing
- Reset: state IDLE, counter 0, flags 0. All outputs 0 except miss_ready=1. Data/address outputs are 0.
- Reset mid-refill aborts immediately. No further arr_we, tag_we or pulses are issued. Beats still in flight after reset are ignored.
- Miss accepted at cycle t → mem_req_valid from t+1 until the handshake cycle inclusive.
- Beat at cycle c → arr_we at c+1.
- Last beat at cL → tag_we and refill_done at cL+1, miss_ready=1 at cL+2.
- Back-to-back misses: the next miss can be accepted at cL+2.
- mem_req_ready may be high before mem_req_valid. Only the handshake cycle counts.

## Configuration
- ICACHE_REFILL_FWD_EN defined: fwd_valid pulses together with the arr_we of the beat whose index equals the latched word offset, and fwd_data equals that beat. On error refills the forward still fires; the consumer qualifies it with refill_err.
- Undefined: fwd_valid and fwd_data ports and their logic are absent. All other behaviour is identical.

## Structure
- Package icache_pkg holds:
  - the refill state enum (IDLE/REQ/FILL/DONE)
  - BEATS, offset-width and beat-index-width constants derived from the parameters
- Single module with no sub-modules. The beat counter and FSM are inline.

## Test plan
- Clean refill. Defaults; miss_addr=0x0000_1234; ready one cycle later; 4 beats 0xA0..0xA3, last on beat 3 → mem_req_addr=0x1230; arr writes to 0x1230/0x1234/0x1238/0x123C; tag_we+refill_done at cL+1.
- Error beat. mem_rsp_err on beat 1 → all 4 arr_we occur; tag_we=0; refill_err pulses once.
- Early last. mem_rsp_last on beat 2 → terminate after 3 writes; refill_err; miss_ready returns 2 cycles later.
- Reset mid-FILL. Reset asserted after beat 1, beats 2–3 still arrive → no arr_we for beats 2–3, no tag_we; miss_ready=1 the cycle after reset.
- Back-to-back. Second miss 0x0000_2000 held high during the first refill → not accepted until cL+2; then mem_req_addr=0x2000.
- FWD (macro on). miss_addr=0x1238 → fwd_valid exactly once, with the beat-2 arr_we, fwd_data=0xA2.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
//
// Shared definitions for the instruction-cache miss-refill sequencer.
//   * Default geometry of the refill path (address width, beat width,
//     line size) and the constants derived from it: beats per line, line
//     offset width and beat-index width.
//   * The refill FSM state enum.
//   * A helper that derives beats-per-line for any parameterisation, so the
//     controller computes its own constants from its instance parameters
//     with the same rule used for the package defaults.
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int ICACHE_ADDR_W     = 32;
    localparam int ICACHE_DATA_W     = 32;
    localparam int ICACHE_LINE_BYTES = 16;

    // Number of memory beats that make up one cache line.
    function automatic int beats_of(input int line_bytes, input int data_w);
        return line_bytes / (data_w / 8);
    endfunction

    localparam int BEATS = beats_of(ICACHE_LINE_BYTES, ICACHE_DATA_W);
    localparam int OFF_W = $clog2(ICACHE_LINE_BYTES);
    localparam int IDX_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//
// Miss-refill sequencer for the instruction cache. Accepts one line miss at a
// time, issues a single line-aligned burst read, writes each returned beat to
// the data array one cycle after it arrives, then commits the tag/valid entry
// (or reports failure without touching the tag).
//
// Parameters
//   ADDR_W      byte-address width
//   DATA_W      memory beat / array word width (multiple of 8)
//   LINE_BYTES  cache line size; LINE_BYTES/(DATA_W/8) is a power of two >= 2
//
// Ports
//   clock, reset            single rising-edge clock, synchronous active-high
//                           reset
//   miss_valid/miss_addr    miss from the lookup stage, held until accepted
//   miss_ready              high only while idle
//   mem_req_valid/addr      burst read request (line-aligned, stable)
//   mem_req_ready           memory accepts the request
//   mem_rsp_valid/data/last/err
//                           returned beats, no backpressure
//   arr_we/arr_addr/arr_wdata
//                           data-array write (word-aligned byte address)
//   tag_we                  tag/valid commit; tag taken from arr_addr line bits
//   refill_done             one-cycle pulse: line committed
//   refill_err              one-cycle pulse: refill failed, tag not written
//   fwd_valid/fwd_data      critical-word forward (only with the macro below)
//
// Build option
//   ICACHE_REFILL_FWD_EN    when defined, adds fwd_valid/fwd_data: a pulse
//                           coincident with the array write of the beat that
//                           holds the originally missing word. It also fires
//                           on failed refills; the consumer qualifies it with
//                           refill_err.
// -----------------------------------------------------------------------------
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = ICACHE_ADDR_W,
    parameter int DATA_W     = ICACHE_DATA_W,
    parameter int LINE_BYTES = ICACHE_LINE_BYTES
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,

    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,

    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_last,
    input  logic              mem_rsp_err,

    output logic              arr_we,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [DATA_W-1:0] arr_wdata,

    output logic              tag_we,
    output logic              refill_done,
    output logic              refill_err
`ifdef ICACHE_REFILL_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int N_BEATS = beats_of(LINE_BYTES, DATA_W);
    localparam int CNT_W   = $clog2(N_BEATS);
    localparam int WB_W    = $clog2(DATA_W / 8);

    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N_BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));

    refill_state_e     state_q,   state_d;
    logic [ADDR_W-1:0] line_q,    line_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              err_q,     err_d;

    // Registered beat: the array write happens the cycle after the beat.
    logic              wr_vld_q,  wr_vld_d;
    logic [CNT_W-1:0]  wr_idx_q,  wr_idx_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

`ifdef ICACHE_REFILL_FWD_EN
    logic [CNT_W-1:0]  woff_q,    woff_d;
`endif

    logic              beat_is_final;
    logic              beat_is_bad;

    // -------------------------------------------------------------------------
    // Next-state and control outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        wr_vld_d      = 1'b0;
        wr_idx_d      = wr_idx_q;
        wr_data_d     = wr_data_q;
`ifdef ICACHE_REFILL_FWD_EN
        woff_d        = woff_q;
`endif
        beat_is_final = 1'b0;
        beat_is_bad   = 1'b0;

        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        tag_we        = 1'b0;
        refill_done   = 1'b0;
        refill_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    line_d  = miss_addr & LINE_MASK;
`ifdef ICACHE_REFILL_FWD_EN
                    woff_d  = CNT_W'(miss_addr >> WB_W);
`endif
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_FILL;
                end
            end

            ST_FILL: begin
                if (mem_rsp_valid) begin
                    wr_vld_d  = 1'b1;
                    wr_idx_d  = cnt_q;
                    wr_data_d = mem_rsp_data;
                    cnt_d     = cnt_q + 1'b1;

                    // The burst ends at the first 'last' or at the final slot.
                    // A 'last' that disagrees with the slot position (early,
                    // or missing on the final slot) marks the line bad.
                    beat_is_final = mem_rsp_last || (cnt_q == LAST_IDX);
                    beat_is_bad   = mem_rsp_err ||
                                    (mem_rsp_last != (cnt_q == LAST_IDX));

                    if (beat_is_bad) begin
                        err_d = 1'b1;
                    end
                    if (beat_is_final) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // The final array write is issued in this same cycle by
                // the registered beat path.
                tag_we      = ~err_q;
                refill_done = ~err_q;
                refill_err  = err_q;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers; reset also clears the data/address path so all
    // outputs are zero after reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
`ifdef ICACHE_REFILL_FWD_EN
            woff_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wr_vld_q  <= wr_vld_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
`ifdef ICACHE_REFILL_FWD_EN
            woff_q    <= woff_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Datapath outputs
    // -------------------------------------------------------------------------
    assign mem_req_addr = line_q;
    assign arr_we       = wr_vld_q;
    assign arr_addr     = line_q + (ADDR_W'(wr_idx_q) << WB_W);
    assign arr_wdata    = wr_data_q;

`ifdef ICACHE_REFILL_FWD_EN
    assign fwd_valid = wr_vld_q && (wr_idx_q == woff_q);
    assign fwd_data  = wr_data_q;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
//
// Self-checking bench for icache_refill_ctrl (default geometry: 32-bit
// address, 32-bit beats, 16-byte lines, 4 beats). Directed refills from the
// feature list followed by randomized refills. A monitor logs every array
// write, completion pulse and (when built with ICACHE_REFILL_FWD_EN) forward
// pulse with its cycle number; after each refill the log is compared with
// what a line refill must produce given the beats that were sent.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_BYTES = 16;
    localparam int NB         = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              miss_valid;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_ready;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              mem_rsp_last;
    logic              mem_rsp_err;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic              tag_we;
    logic              refill_done;
    logic              refill_err;
`ifdef ICACHE_REFILL_FWD_EN
    logic              fwd_valid;
    logic [DATA_W-1:0] fwd_data;
`endif

    icache_refill_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_BYTES (LINE_BYTES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .miss_ready    (miss_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_last  (mem_rsp_last),
        .mem_rsp_err   (mem_rsp_err),
        .arr_we        (arr_we),
        .arr_addr      (arr_addr),
        .arr_wdata     (arr_wdata),
        .tag_we        (tag_we),
        .refill_done   (refill_done),
        .refill_err    (refill_err)
`ifdef ICACHE_REFILL_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_data      (fwd_data)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    typedef struct {
        int   c;
        logic tag;
        logic done;
        logic err;
    } ev_t;

    wr_t wr_q[$];
    ev_t ev_q[$];
    wr_t fw_q[$];
    wr_t mon_w;
    ev_t mon_e;

    always @(negedge clock) begin
        if (arr_we === 1'b1) begin
            mon_w.c = cyc; mon_w.a = arr_addr; mon_w.d = arr_wdata;
            wr_q.push_back(mon_w);
        end
        if ((tag_we | refill_done | refill_err) === 1'b1) begin
            mon_e.c = cyc; mon_e.tag = tag_we; mon_e.done = refill_done; mon_e.err = refill_err;
            ev_q.push_back(mon_e);
        end
`ifdef ICACHE_REFILL_FWD_EN
        if (fwd_valid === 1'b1) begin
            mon_w.c = cyc; mon_w.a = '0; mon_w.d = fwd_data;
            fw_q.push_back(mon_w);
        end
`endif
    end

    // ---------------- refill description ----------------
    logic [31:0] bd[NB];
    bit          be[NB];
    bit          bl[NB];
    int          bc[NB];

    task automatic clear_beats();
        for (int i = 0; i < NB; i++) begin
            bd[i] = 32'hA0 + 32'(i); be[i] = 1'b0; bl[i] = 1'b0; bc[i] = 0;
        end
    endtask

    // Drive one refill and check it. Called and returns at a point just after
    // a falling edge. nb = beats to send; rst_after >= 0 pulses reset after
    // that beat's write, with remaining beats still sent.
    task automatic run_refill(input logic [31:0] addr, input int nb, input int rdy_dly,
                              input bit pre_rdy, input bit hold_nxt, input logic [31:0] nxt,
                              input int rst_after, input bit stray, input bit rnd_gap);
        int          n;
        int          term;
        int          n_exp;
        int          fw_exp;
        bit          err;
        logic [31:0] line;
        int          woff;

        line = addr & ~32'(LINE_BYTES - 1);
        woff = int'((addr >> 2) & 32'h3);

        n = 0;
        while (miss_ready !== 1'b1 && n < 50) begin
            @(negedge clock); n++;
        end
        chk("miss_ready_idle", 64'(miss_ready), 64'd1);

        miss_valid    = 1'b1;
        miss_addr     = addr;
        mem_req_ready = pre_rdy;
        @(posedge clock); #1;
        if (hold_nxt) miss_addr = nxt;
        else          miss_valid = 1'b0;
        mem_req_ready = 1'b0;

        for (int k = 0; k <= rdy_dly; k++) begin
            if (k == rdy_dly) mem_req_ready = 1'b1;
            @(negedge clock);
            chk("req_valid", 64'(mem_req_valid), 64'd1);
            chk("req_addr", 64'(mem_req_addr), 64'(line));
            chk("miss_ready_busy", 64'(miss_ready), 64'd0);
            @(posedge clock); #1;
            mem_req_ready = 1'b0;
        end
        @(negedge clock);
        chk("req_valid_after_hs", 64'(mem_req_valid), 64'd0);
        @(posedge clock); #1;

        for (int i = 0; i < nb; i++) begin
            if (rnd_gap) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock); #1;
                end
            end
            if (rst_after >= 0 && i == rst_after + 1) begin
                reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
                @(negedge clock);
                chk("rst_miss_ready", 64'(miss_ready), 64'd1);
                chk("rst_no_req", 64'(mem_req_valid), 64'd0);
                @(posedge clock); #1;
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = bd[i];
            mem_rsp_err   = be[i];
            mem_rsp_last  = bl[i];
            bc[i] = cyc;
            @(posedge clock); #1;
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_last = 1'b0;
        end

        // Beat arriving while the line is being committed must be ignored.
        if (stray) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = $urandom;
            mem_rsp_last  = 1'($urandom_range(0, 1));
            mem_rsp_err   = 1'($urandom_range(0, 1));
        end
        @(negedge clock);
        if (rst_after < 0) chk("miss_ready_cL1", 64'(miss_ready), 64'd0);
        chk("req_idle_cL1", 64'(mem_req_valid), 64'd0);
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_last = 1'b0;
        @(negedge clock);
        chk("miss_ready_cL2", 64'(miss_ready), 64'd1);
        chk("req_idle_cL2", 64'(mem_req_valid), 64'd0);
        #1;

        // ---- expected behaviour of a line refill ----
        term = NB - 1;
        for (int i = 0; i < NB; i++) begin
            if (bl[i] || i == NB - 1) begin term = i; break; end
        end
        err = 1'b0;
        for (int i = 0; i <= term; i++) begin
            if (be[i]) err = 1'b1;
            if (bl[i] && i != NB - 1) err = 1'b1;
            if (i == NB - 1 && !bl[i]) err = 1'b1;
        end
        n_exp = (rst_after >= 0) ? rst_after + 1 : term + 1;

        chk("wr_count", 64'(wr_q.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
            chk("wr_cycle", 64'(wr_q[i].c), 64'(bc[i] + 1));
            chk("wr_addr", 64'(wr_q[i].a), 64'(line + 32'(4 * i)));
            chk("wr_data", 64'(wr_q[i].d), 64'(bd[i]));
        end

        if (rst_after >= 0) begin
            chk("rst_no_commit", 64'(ev_q.size()), 64'd0);
        end else begin
            chk("commit_count", 64'(ev_q.size()), 64'd1);
            if (ev_q.size() > 0) begin
                chk("commit_cycle", 64'(ev_q[0].c), 64'(bc[term] + 1));
                chk("tag_we", 64'(ev_q[0].tag), 64'(!err));
                chk("refill_done", 64'(ev_q[0].done), 64'(!err));
                chk("refill_err", 64'(ev_q[0].err), 64'(err));
            end
        end

`ifdef ICACHE_REFILL_FWD_EN
        fw_exp = (woff < n_exp) ? 1 : 0;
        chk("fwd_count", 64'(fw_q.size()), 64'(fw_exp));
        if (fw_exp == 1 && fw_q.size() > 0) begin
            chk("fwd_cycle", 64'(fw_q[0].c), 64'(bc[woff] + 1));
            chk("fwd_data", 64'(fw_q[0].d), 64'(bd[woff]));
        end
`else
        fw_exp = woff;
`endif

        wr_q.delete();
        ev_q.delete();
        fw_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int term;

        reset = 1'b1;
        miss_valid = 1'b0; miss_addr = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_last = 1'b0; mem_rsp_err = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_miss_ready", 64'(miss_ready), 64'd1);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(mem_req_addr), 64'd0);
        chk("rst_arr_we", 64'(arr_we), 64'd0);
        chk("rst_arr_addr", 64'(arr_addr), 64'd0);
        chk("rst_arr_wdata", 64'(arr_wdata), 64'd0);
        chk("rst_pulses", 64'({tag_we, refill_done, refill_err}), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock); #1;
        wr_q.delete(); ev_q.delete(); fw_q.delete();

        // Clean refill
        clear_beats(); bl[3] = 1'b1;
        run_refill(32'h0000_1234, 4, 1, 1'b0, 1'b0, 32'h0, -1, 1'b0, 1'b0);

        // Error on beat 1: all four writes, no tag
        clear_beats(); bl[3] = 1'b1; be[1] = 1'b1;
        run_refill(32'h0000_5670, 4, 0, 1'b1, 1'b0, 32'h0, -1, 1'b0, 1'b0);

        // Early last on beat 2
        clear_beats(); bl[2] = 1'b1;
        run_refill(32'h0000_9ABC, 3, 2, 1'b0, 1'b0, 32'h0, -1, 1'b1, 1'b0);

        // Missing last on final beat
        clear_beats();
        run_refill(32'h0000_4000, 4, 0, 1'b0, 1'b0, 32'h0, -1, 1'b0, 1'b1);

        // Reset after beat 1, beats 2-3 still arrive
        clear_beats(); bl[3] = 1'b1;
        run_refill(32'h0000_1234, 4, 0, 1'b0, 1'b0, 32'h0, 1, 1'b0, 1'b0);

        // Back-to-back: second miss held during the first refill
        clear_beats(); bl[3] = 1'b1;
        run_refill(32'h0000_1234, 4, 0, 1'b0, 1'b1, 32'h0000_2000, -1, 1'b0, 1'b0);
        clear_beats(); bl[3] = 1'b1;
        for (int i = 0; i < NB; i++) bd[i] = 32'hB0 + 32'(i);
        run_refill(32'h0000_2000, 4, 0, 1'b0, 1'b0, 32'h0, -1, 1'b0, 1'b0);

        // Critical word in beat 2
        clear_beats(); bl[3] = 1'b1;
        run_refill(32'h0000_1238, 4, 0, 1'b0, 1'b0, 32'h0, -1, 1'b0, 1'b0);

        // Randomized refills
        for (int r = 0; r < 20; r++) begin
            term = $urandom_range(0, NB - 1);
            for (int i = 0; i < NB; i++) begin
                bd[i] = $urandom;
                be[i] = ($urandom_range(0, 7) == 0);
                bl[i] = (i == term) ? ((term < NB - 1) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                bc[i] = 0;
            end
            run_refill($urandom, term + 1, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       1'b0, 32'h0, -1, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
